// File: rtl/axil_reg_bridge_pkg.sv
// Shared types and constants for the AXI-Lite to register-host bridge.
// Holds the AXI response codes, the per-transaction tag pushed at acceptance,
// and the width helper for the downstream response (data) entry.
package axil_reg_bridge_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // One tag per accepted transaction, kept in acceptance order.
  // derr marks an out-of-window access that never reaches the peripheral.
  typedef struct packed {
    logic we;
    logic derr;
  } bridge_tag_s;

  // Data entry is {rdata, err}; the struct itself is declared where the
  // data width parameter is known.
  function automatic int data_entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-array FIFO, one push and one pop port.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   v_i, data_i         push; allowed when full only if yumi_i pops the same cycle
//   ready_o             not full
//   v_o, data_o         head valid / head data (from storage, no input path)
//   yumi_i              pop the head
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0]   wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0]   cnt_q;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (v_i)    wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (yumi_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({v_i, yumi_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; v_o qualifies data_o.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign ready_o = (cnt_q != full_cnt);
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(v_i && !ready_o && !yumi_i))
    else $error("bsg_fifo_1r1w_small: push while full");

  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o))
    else $error("bsg_fifo_1r1w_small: pop while empty");

endmodule

// File: rtl/axil_reg_host_bridge.sv
// AXI4-Lite client to req/gnt/valid register-host bridge.
// Accepts up to max_outstanding_p transactions, round-robins reads against
// writes, decodes a 2^reg_addr_width_p byte window at base_addr_p and answers
// out-of-window accesses with DECERR locally. Responses return in acceptance
// order: a tag FIFO records every accept, a data FIFO collects peripheral
// responses for in-window tags.
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   s_axil_aw*/w*/b*/ar*/r*         AXI4-Lite client (prot ignored)
//   req_o/gnt_i                     downstream request handshake
//   addr_o, we_o, wdata_o, be_o     request payload, stable while req_o
//   valid_i, rdata_i, err_i         in-order downstream response, no back-pressure
module axil_reg_host_bridge
  import axil_reg_bridge_pkg::*;
#(
  parameter int                           axil_data_width_p = 32,
  parameter int                           axil_addr_width_p = 32,
  parameter int                           reg_addr_width_p  = 22,
  parameter logic [axil_addr_width_p-1:0] base_addr_p       = '0,
  parameter int                           max_outstanding_p = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,
  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,
  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,
  output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,
  output logic                           req_o,
  input  logic                           gnt_i,
  output logic [reg_addr_width_p-1:0]    addr_o,
  output logic                           we_o,
  output logic [axil_data_width_p-1:0]   wdata_o,
  output logic [axil_data_width_p/8-1:0] be_o,
  input  logic                           valid_i,
  input  logic [axil_data_width_p-1:0]   rdata_i,
  input  logic                           err_i
);

  localparam int strb_w  = axil_data_width_p / 8;
  localparam int cnt_w   = $clog2(max_outstanding_p + 1);
  localparam int entry_w = data_entry_width(axil_data_width_p);

  typedef struct packed {
    logic [axil_data_width_p-1:0] rdata;
    logic                         err;
  } data_entry_s;

  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot_i, s_axil_arprot_i};

  // Readies stay low for the first cycle after reset release.
  logic ready_en_q;
  logic last_wr_q;

  logic                         cmd_v_q, cmd_we_q;
  logic [reg_addr_width_p-1:0]  cmd_addr_q;
  logic [axil_data_width_p-1:0] cmd_wdata_q;
  logic [strb_w-1:0]            cmd_be_q;

  bridge_tag_s tag_in, tag_head;
  logic        tag_ready, tag_v, tag_pop;
  data_entry_s data_in, data_head;
  logic        data_ready, data_v, data_pop;

  logic grant, wr_elig, rd_elig, pick_wr, can_accept;
  logic accept_wr, accept_rd, accept, in_win;
  logic [axil_addr_width_p-1:0] acc_addr;

  assign grant   = cmd_v_q & gnt_i;
  assign wr_elig = s_axil_awvalid_i & s_axil_wvalid_i;
  assign rd_elig = s_axil_arvalid_i;
  // last_wr_q=0 after reset, so a write wins the first contended cycle.
  assign pick_wr = wr_elig & (~rd_elig | ~last_wr_q);

  // A full tag FIFO may still accept when its head is retiring this cycle.
  assign can_accept = ready_en_q & (tag_ready | tag_pop) & (~cmd_v_q | grant);
  assign accept_wr  = can_accept & pick_wr;
  assign accept_rd  = can_accept & rd_elig & ~pick_wr;
  assign accept     = accept_wr | accept_rd;

  assign acc_addr = accept_wr ? s_axil_awaddr_i : s_axil_araddr_i;
  assign in_win   = (acc_addr[axil_addr_width_p-1:reg_addr_width_p] ==
                     base_addr_p[axil_addr_width_p-1:reg_addr_width_p]);

  assign s_axil_awready_o = accept_wr;
  assign s_axil_wready_o  = accept_wr;
  assign s_axil_arready_o = accept_rd;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_en_q <= 1'b0;
      last_wr_q  <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) last_wr_q <= accept_wr;
    end
  end

  // Command register: a new load wins over a same-cycle grant.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_v_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
    end else if (accept && in_win) begin
      cmd_v_q     <= 1'b1;
      cmd_we_q    <= accept_wr;
      cmd_addr_q  <= acc_addr[reg_addr_width_p-1:0];
      cmd_wdata_q <= accept_wr ? s_axil_wdata_i : '0;
      cmd_be_q    <= accept_wr ? s_axil_wstrb_i : '1;
    end else if (grant) begin
      cmd_v_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
    end
  end

  assign req_o   = cmd_v_q;
  assign we_o    = cmd_we_q;
  assign addr_o  = cmd_addr_q;
  assign wdata_o = cmd_wdata_q;
  assign be_o    = cmd_be_q;

  assign tag_in = '{we: accept_wr, derr: ~in_win};

  bsg_fifo_1r1w_small #(
    .width_p($bits(bridge_tag_s)),
    .els_p  (max_outstanding_p)
  ) tag_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (accept),
    .data_i (tag_in),
    .ready_o(tag_ready),
    .v_o    (tag_v),
    .data_o (tag_head),
    .yumi_i (tag_pop)
  );

  assign data_in = '{rdata: rdata_i, err: err_i};

  bsg_fifo_1r1w_small #(
    .width_p(entry_w),
    .els_p  (max_outstanding_p)
  ) data_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (valid_i),
    .data_i (data_in),
    .ready_o(data_ready),
    .v_o    (data_v),
    .data_o (data_head),
    .yumi_i (data_pop)
  );

  // Response side is driven only from FIFO state, so it holds until the
  // handshake; payloads are forced to zero while not valid.
  logic       resp_avail;
  logic [1:0] resp_code;

  assign resp_avail = tag_v & (tag_head.derr | data_v);
  assign resp_code  = tag_head.derr ? DECERR : (data_head.err ? SLVERR : OKAY);

  assign s_axil_bvalid_o = resp_avail & tag_head.we;
  assign s_axil_rvalid_o = resp_avail & ~tag_head.we;
  assign s_axil_bresp_o  = s_axil_bvalid_o ? resp_code : OKAY;
  assign s_axil_rresp_o  = s_axil_rvalid_o ? resp_code : OKAY;
  assign s_axil_rdata_o  = (s_axil_rvalid_o && !tag_head.derr) ? data_head.rdata : '0;

  assign tag_pop  = (s_axil_bvalid_o & s_axil_bready_i) | (s_axil_rvalid_o & s_axil_rready_i);
  assign data_pop = tag_pop & ~tag_head.derr;

  // Granted-but-unanswered count, used only to catch stray downstream responses.
  logic [cnt_w-1:0] gnt_pend_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      gnt_pend_q <= '0;
    end else begin
      case ({grant, valid_i})
        2'b10:   gnt_pend_q <= gnt_pend_q + 1'b1;
        2'b01:   gnt_pend_q <= gnt_pend_q - 1'b1;
        default: gnt_pend_q <= gnt_pend_q;
      endcase
    end
  end

  a_valid_has_request: assert property (@(posedge clk_i) disable iff (reset_i)
    valid_i |-> ((gnt_pend_q != '0) || grant) && (data_ready || data_pop))
    else $error("axil_reg_host_bridge: valid_i without an outstanding granted request");

endmodule

// File: tb/tb_axil_reg_host_bridge.sv
module tb_axil_reg_host_bridge;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] s_axil_awaddr_i;
  logic [2:0]  s_axil_awprot_i;
  logic        s_axil_awvalid_i;
  logic        s_axil_awready_o;
  logic [31:0] s_axil_wdata_i;
  logic [3:0]  s_axil_wstrb_i;
  logic        s_axil_wvalid_i;
  logic        s_axil_wready_o;
  logic [1:0]  s_axil_bresp_o;
  logic        s_axil_bvalid_o;
  logic        s_axil_bready_i;
  logic [31:0] s_axil_araddr_i;
  logic [2:0]  s_axil_arprot_i;
  logic        s_axil_arvalid_i;
  logic        s_axil_arready_o;
  logic [31:0] s_axil_rdata_o;
  logic [1:0]  s_axil_rresp_o;
  logic        s_axil_rvalid_o;
  logic        s_axil_rready_i;
  logic        req_o;
  logic        gnt_i;
  logic [21:0] addr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic        valid_i;
  logic [31:0] rdata_i;
  logic        err_i;

  axil_reg_host_bridge #(
    .axil_data_width_p(32),
    .axil_addr_width_p(32),
    .reg_addr_width_p (22),
    .base_addr_p      (32'h0),
    .max_outstanding_p(2)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .s_axil_awaddr_i (s_axil_awaddr_i),
    .s_axil_awprot_i (s_axil_awprot_i),
    .s_axil_awvalid_i(s_axil_awvalid_i),
    .s_axil_awready_o(s_axil_awready_o),
    .s_axil_wdata_i  (s_axil_wdata_i),
    .s_axil_wstrb_i  (s_axil_wstrb_i),
    .s_axil_wvalid_i (s_axil_wvalid_i),
    .s_axil_wready_o (s_axil_wready_o),
    .s_axil_bresp_o  (s_axil_bresp_o),
    .s_axil_bvalid_o (s_axil_bvalid_o),
    .s_axil_bready_i (s_axil_bready_i),
    .s_axil_araddr_i (s_axil_araddr_i),
    .s_axil_arprot_i (s_axil_arprot_i),
    .s_axil_arvalid_i(s_axil_arvalid_i),
    .s_axil_arready_o(s_axil_arready_o),
    .s_axil_rdata_o  (s_axil_rdata_o),
    .s_axil_rresp_o  (s_axil_rresp_o),
    .s_axil_rvalid_o (s_axil_rvalid_o),
    .s_axil_rready_i (s_axil_rready_i),
    .req_o           (req_o),
    .gnt_i           (gnt_i),
    .addr_o          (addr_o),
    .we_o            (we_o),
    .wdata_o         (wdata_o),
    .be_o            (be_o),
    .valid_i         (valid_i),
    .rdata_i         (rdata_i),
    .err_i           (err_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, got, exp);
    end
  endtask

  // Downstream peripheral model: fixed data pattern per address, configurable
  // grant-to-response latency, optional hold to withhold responses.
  function automatic logic [31:0] ds_data(input logic [21:0] a);
    if (a == 22'h10) return 32'hDEADBEEF;
    return {10'h2A5, a};
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } ds_ent_t;

  ds_ent_t ds_q[$];
  int      cyc       = 0;
  int      grant_cnt = 0;
  int      ds_lat    = 1;
  bit      ds_hold   = 1'b0;
  logic    ds_err    = 1'b0;

  always @(posedge clk_i) begin
    if (!reset_i && req_o && gnt_i) begin
      ds_q.push_back('{cyc + ds_lat, ds_data(addr_o), ds_err});
      grant_cnt <= grant_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk_i) begin
    if (reset_i) begin
      ds_q.delete();
      valid_i = 1'b0;
      rdata_i = '0;
      err_i   = 1'b0;
    end else if (!ds_hold && ds_q.size() > 0 && ds_q[0].due <= cyc) begin
      valid_i = 1'b1;
      rdata_i = ds_q[0].data;
      err_i   = ds_q[0].err;
      void'(ds_q.pop_front());
    end else begin
      valid_i = 1'b0;
      rdata_i = '0;
      err_i   = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]  kinds[$];
  logic [31:0] dats[$];
  logic [1:0]  rsps[$];
  logic [7:0]  acc_seq[$];
  int          g0;
  int          n;
  bit          c_acc;

  initial begin
    reset_i          = 1'b1;
    s_axil_awaddr_i  = '0;
    s_axil_awprot_i  = '0;
    s_axil_awvalid_i = 1'b1;
    s_axil_wdata_i   = '0;
    s_axil_wstrb_i   = 4'hF;
    s_axil_wvalid_i  = 1'b1;
    s_axil_bready_i  = 1'b1;
    s_axil_araddr_i  = '0;
    s_axil_arprot_i  = '0;
    s_axil_arvalid_i = 1'b1;
    s_axil_rready_i  = 1'b1;
    gnt_i            = 1'b1;

    // Reset state with valids asserted
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_awready", s_axil_awready_o, 1'b0);
    chk("rst_arready", s_axil_arready_o, 1'b0);
    chk("rst_req", req_o, 1'b0);
    chk("rst_bvalid", s_axil_bvalid_o, 1'b0);
    chk("rst_rvalid", s_axil_rvalid_o, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("post_rst_awready", s_axil_awready_o, 1'b0);
    chk("post_rst_arready", s_axil_arready_o, 1'b0);
    @(negedge clk_i);
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    s_axil_arvalid_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Single read, exact latency
    s_axil_araddr_i  = 32'h10;
    s_axil_arvalid_i = 1'b1;
    #1 chk("t1_arready", s_axil_arready_o, 1'b1);
    @(negedge clk_i);
    s_axil_arvalid_i = 1'b0;
    #1;
    chk("t1_req", req_o, 1'b1);
    chk("t1_addr", addr_o, 22'h10);
    chk("t1_be", be_o, 4'hF);
    chk("t1_we", we_o, 1'b0);
    @(negedge clk_i); #1;
    chk("t1_rvalid_c2", s_axil_rvalid_o, 1'b0);
    chk("t1_req_c2", req_o, 1'b0);
    @(negedge clk_i); #1;
    chk("t1_rvalid_c3", s_axil_rvalid_o, 1'b1);
    chk("t1_rdata", s_axil_rdata_o, 32'hDEADBEEF);
    chk("t1_rresp", s_axil_rresp_o, 2'b00);
    @(negedge clk_i); #1;
    chk("t1_rvalid_pop", s_axil_rvalid_o, 1'b0);

    // Partial write
    @(negedge clk_i);
    s_axil_awaddr_i  = 32'h20;
    s_axil_wdata_i   = 32'h11223344;
    s_axil_wstrb_i   = 4'b0011;
    s_axil_awvalid_i = 1'b1;
    s_axil_wvalid_i  = 1'b1;
    #1;
    chk("t2_awready", s_axil_awready_o, 1'b1);
    chk("t2_wready", s_axil_wready_o, 1'b1);
    @(negedge clk_i);
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    #1;
    chk("t2_req", req_o, 1'b1);
    chk("t2_we", we_o, 1'b1);
    chk("t2_be", be_o, 4'b0011);
    chk("t2_wdata", wdata_o, 32'h11223344);
    chk("t2_addr", addr_o, 22'h20);
    @(negedge clk_i); #1;
    chk("t2_bvalid_c2", s_axil_bvalid_o, 1'b0);
    @(negedge clk_i); #1;
    chk("t2_bvalid_c3", s_axil_bvalid_o, 1'b1);
    chk("t2_bresp", s_axil_bresp_o, 2'b00);
    chk("t2_rvalid", s_axil_rvalid_o, 1'b0);

    // Downstream error -> SLVERR
    @(negedge clk_i);
    ds_err           = 1'b1;
    s_axil_araddr_i  = 32'h30;
    s_axil_arvalid_i = 1'b1;
    #1 chk("t7_arready", s_axil_arready_o, 1'b1);
    @(negedge clk_i);
    s_axil_arvalid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("t7_rvalid", s_axil_rvalid_o, 1'b1);
    chk("t7_rresp", s_axil_rresp_o, 2'b10);
    chk("t7_rdata", s_axil_rdata_o, 32'hA9400030);
    ds_err = 1'b0;

    // Out-of-window read -> DECERR at cycle 1, no downstream request
    @(negedge clk_i);
    g0               = grant_cnt;
    s_axil_araddr_i  = 32'h0040_0000;
    s_axil_arvalid_i = 1'b1;
    #1 chk("t3_arready", s_axil_arready_o, 1'b1);
    @(negedge clk_i);
    s_axil_arvalid_i = 1'b0;
    #1;
    chk("t3_rvalid", s_axil_rvalid_o, 1'b1);
    chk("t3_rresp", s_axil_rresp_o, 2'b11);
    chk("t3_rdata", s_axil_rdata_o, 32'h0);
    chk("t3_req", req_o, 1'b0);
    @(negedge clk_i); #1;
    chk("t3_rvalid_pop", s_axil_rvalid_o, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("t3_no_grant", grant_cnt, g0);

    // Ordering: A (read), B (write, out of window), C (read), latency 5
    ds_lat = 5;
    @(negedge clk_i);
    s_axil_araddr_i  = 32'h100;
    s_axil_arvalid_i = 1'b1;
    #1 chk("t4_a_acc", s_axil_arready_o, 1'b1);
    @(negedge clk_i);
    s_axil_arvalid_i = 1'b0;
    s_axil_awaddr_i  = 32'h0080_0000;
    s_axil_wdata_i   = 32'h55AA55AA;
    s_axil_wstrb_i   = 4'hF;
    s_axil_awvalid_i = 1'b1;
    s_axil_wvalid_i  = 1'b1;
    #1 chk("t4_b_acc", s_axil_awready_o, 1'b1);
    @(negedge clk_i);
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    s_axil_araddr_i  = 32'h104;
    s_axil_arvalid_i = 1'b1;
    #1 chk("t4_full_wait", s_axil_arready_o, 1'b0);
    n = 0;
    c_acc = 1'b0;
    while (kinds.size() < 3 && n < 40) begin
      if (s_axil_arvalid_i && s_axil_arready_o) c_acc = 1'b1;
      if (s_axil_rvalid_o) begin
        kinds.push_back("R"); dats.push_back(s_axil_rdata_o); rsps.push_back(s_axil_rresp_o);
      end
      if (s_axil_bvalid_o) begin
        kinds.push_back("B"); dats.push_back(32'h0); rsps.push_back(s_axil_bresp_o);
      end
      @(negedge clk_i);
      if (c_acc) s_axil_arvalid_i = 1'b0;
      #1;
      n++;
    end
    chk("t4_count", kinds.size(), 3);
    if (kinds.size() == 3) begin
      chk("t4_first_kind", kinds[0], "R");
      chk("t4_first_data", dats[0], 32'hA9400100);
      chk("t4_first_resp", rsps[0], 2'b00);
      chk("t4_second_kind", kinds[1], "B");
      chk("t4_second_resp", rsps[1], 2'b11);
      chk("t4_third_kind", kinds[2], "R");
      chk("t4_third_data", dats[2], 32'hA9400104);
      chk("t4_third_resp", rsps[2], 2'b00);
    end
    ds_lat = 1;
    s_axil_arvalid_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Full tag FIFO, then R back-pressure
    ds_hold          = 1'b1;
    s_axil_rready_i  = 1'b0;
    s_axil_araddr_i  = 32'h200;
    s_axil_arvalid_i = 1'b1;
    #1 chk("t5_acc0", s_axil_arready_o, 1'b1);
    @(negedge clk_i);
    s_axil_araddr_i = 32'h204;
    #1 chk("t5_acc1", s_axil_arready_o, 1'b1);
    @(negedge clk_i);
    s_axil_araddr_i  = 32'h208;
    s_axil_awaddr_i  = 32'h300;
    s_axil_awvalid_i = 1'b1;
    s_axil_wvalid_i  = 1'b1;
    #1;
    chk("t5_full_arready", s_axil_arready_o, 1'b0);
    chk("t5_full_awready", s_axil_awready_o, 1'b0);
    chk("t5_full_wready", s_axil_wready_o, 1'b0);
    @(negedge clk_i); #1;
    chk("t5_full_arready2", s_axil_arready_o, 1'b0);
    @(negedge clk_i);
    s_axil_arvalid_i = 1'b0;
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    ds_hold          = 1'b0;
    #1;
    n = 0;
    while (!s_axil_rvalid_o && n < 20) begin
      @(negedge clk_i); #1; n++;
    end
    chk("t5_rvalid", s_axil_rvalid_o, 1'b1);
    chk("t5_rdata", s_axil_rdata_o, 32'hA9400200);
    repeat (3) @(negedge clk_i);
    #1;
    chk("t5_hold_valid", s_axil_rvalid_o, 1'b1);
    chk("t5_hold_data", s_axil_rdata_o, 32'hA9400200);
    chk("t5_hold_resp", s_axil_rresp_o, 2'b00);
    @(negedge clk_i);
    s_axil_rready_i = 1'b1;
    @(negedge clk_i); #1;
    chk("t5_second_valid", s_axil_rvalid_o, 1'b1);
    chk("t5_second_data", s_axil_rdata_o, 32'hA9400204);
    @(negedge clk_i); #1;
    chk("t5_drained", s_axil_rvalid_o, 1'b0);

    // Contention: continuous AW/W and AR, alternating grants
    @(negedge clk_i);
    reset_i          = 1'b1;
    s_axil_awaddr_i  = 32'h40;
    s_axil_wdata_i   = 32'hCAFEF00D;
    s_axil_wstrb_i   = 4'hF;
    s_axil_awvalid_i = 1'b1;
    s_axil_wvalid_i  = 1'b1;
    s_axil_araddr_i  = 32'h44;
    s_axil_arvalid_i = 1'b1;
    #1 chk("t6_rst_awready", s_axil_awready_o, 1'b0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    #1 chk("t6_post_rst_arready", s_axil_arready_o, 1'b0);
    n = 0;
    while (acc_seq.size() < 4 && n < 30) begin
      @(negedge clk_i); #1;
      chk("t6_single_accept", s_axil_awready_o & s_axil_arready_o, 1'b0);
      if (s_axil_awready_o) acc_seq.push_back("W");
      if (s_axil_arready_o) acc_seq.push_back("R");
      n++;
    end
    chk("t6_accepts", acc_seq.size(), 4);
    if (acc_seq.size() == 4) begin
      chk("t6_seq0", acc_seq[0], "W");
      chk("t6_seq1", acc_seq[1], "R");
      chk("t6_seq2", acc_seq[2], "W");
      chk("t6_seq3", acc_seq[3], "R");
    end

    // Asynchronous reset mid-burst
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    chk("t6_ar_awready", s_axil_awready_o, 1'b0);
    chk("t6_ar_wready", s_axil_wready_o, 1'b0);
    chk("t6_ar_arready", s_axil_arready_o, 1'b0);
    chk("t6_ar_bvalid", s_axil_bvalid_o, 1'b0);
    chk("t6_ar_rvalid", s_axil_rvalid_o, 1'b0);
    chk("t6_ar_req", req_o, 1'b0);
    chk("t6_ar_addr", addr_o, 22'h0);
    chk("t6_ar_we", we_o, 1'b0);
    chk("t6_ar_wdata", wdata_o, 32'h0);
    chk("t6_ar_be", be_o, 4'h0);
    chk("t6_ar_rdata", s_axil_rdata_o, 32'h0);
    chk("t6_ar_resp", {s_axil_bresp_o, s_axil_rresp_o}, 4'h0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    n = 0;
    while (!s_axil_awready_o && !s_axil_arready_o && n < 10) begin
      @(negedge clk_i); #1; n++;
    end
    chk("t6_first_is_write", {s_axil_awready_o, s_axil_arready_o}, 2'b10);
    @(negedge clk_i);
    s_axil_awvalid_i = 1'b0;
    s_axil_wvalid_i  = 1'b0;
    s_axil_arvalid_i = 1'b0;
    repeat (20) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_reg_host_bridge.md
# axil_reg_host_bridge

Parametrised AXI4-Lite client to req/gnt/valid register-host bridge: the next generation of the single-outstanding front end that sits between the Zynq PS AXI-Lite master and register-bus peripherals (rv_plic, future ethernet/timer blocks). It adds the following over the single-outstanding front end:
- up to `max_outstanding_p` in-flight requests;
- strobe-driven byte enables;
- round-robin read/write arbitration;
- address-window decode that returns DECERR without touching the peripheral.

Responses always return in acceptance order.

## Interface
- `axil_data_width_p`, 32, AXI-Lite and register data width.
- `axil_addr_width_p`, 32, AXI-Lite address width.
- `reg_addr_width_p`, 22, downstream address width; window size is 2^`reg_addr_width_p` bytes.
- `base_addr_p`, 'h0, window base; must be aligned to the window size.
- `max_outstanding_p`, 2, maximum accepted-but-unanswered transactions; must be ≥1.

Ports (clock and reset first):
- `clk_i` in 1 — single clock.
- `reset_i` in 1 — asynchronous, active-high reset.
- `s_axil_aw{addr,prot,valid}_i` / `s_axil_awready_o` — AW channel; awprot is ignored.
- `s_axil_w{data,strb,valid}_i` / `s_axil_wready_o` — W channel.
- `s_axil_b{resp,valid}_o` / `s_axil_bready_i` — B channel.
- `s_axil_ar{addr,prot,valid}_i` / `s_axil_arready_o` — AR channel; arprot is ignored.
- `s_axil_r{data,resp,valid}_o` / `s_axil_rready_i` — R channel.
- `req_o` out 1 — downstream request valid.
- `gnt_i` in 1 — request accepted when `req_o & gnt_i`.
- `addr_o` out `reg_addr_width_p` — address offset from `base_addr_p`.
- `we_o` out 1 — write enable.
- `wdata_o` out `axil_data_width_p` — write data.
- `be_o` out `axil_data_width_p/8` — byte enables.
- `valid_i` in 1 — response valid; no back-pressure, one response per granted request, in order.
- `rdata_i` in `axil_data_width_p` — read data.
- `err_i` in 1 — downstream error.

## Operation
**Acceptance**
- A write is accepted only when `awvalid` and `wvalid` are both high.
- At acceptance, `awready` and `wready` pulse together for one cycle.
- A read is accepted when `arvalid` is high; `arready` pulses for one cycle.
- Accept requires the tag FIFO not full and the command register empty (or being granted the same cycle).
- At most one accept per cycle.
- **Arbitration:** if both a write and a read are eligible, round-robin. The last winner is held in a 1-bit pointer; after reset, write wins first.

**Window decode**
- In-window means `addr[axil_addr_width_p-1:reg_addr_width_p] == base_addr_p[...]`.
- Out-of-window: push tag {we, derr=1} only; no downstream request is issued.
- In-window: push tag {we, derr=0} and load the command register {offset, we, wdata, be}.
- `be` = wstrb for writes, all-ones for reads.

**Downstream**
- `req_o` is held with stable payload until `gnt_i`.
- The command register clears on grant.

**Responses**
- `valid_i` pushes {rdata, err} into the data FIFO, depth `max_outstanding_p`. It cannot overflow because accepts are bounded by tag occupancy.
- Head tag with derr=1: present the response immediately, resp=2'b11, rdata=0.
- Head tag with derr=0: wait for the data FIFO to be non-empty; resp=2'b10 if err else 2'b00.
- Writes are presented on B, reads on R.
- The tag is popped on the bvalid&bready or rvalid&rready handshake. The data FIFO is popped at the same handshake for derr=0 tags.
- Write rdata from downstream is discarded.

**Reset**
- All outputs 0 during and immediately after reset: readies, `bvalid`, `rvalid`, `req_o`; payload outputs are also 0.
- FIFOs empty, RR pointer set to write.
- Reset mid-transaction drops all in-flight state. A downstream `valid_i` that arrives after reset deasserts is a protocol violation; flag it with a simulation assertion.

## Timing
**Latency**
- Accept at cycle 0.
- `req_o` high at cycle 1.
- With `gnt_i` at 1 and `valid_i` at 2, B/R valid at cycle 3.
- DECERR response: valid at cycle 1 if the tag is at head.

**Throughput**
- With `gnt_i` tied high and zero-latency responses, one transaction per cycle is sustained once `max_outstanding_p` ≥ 3.
- `bvalid`/`rvalid` and their payloads are registered outputs. Once asserted they hold until ready; AXI rule, no retraction.

**Boundaries**
- **Tag FIFO full:** all readies low.
- **Simultaneous accept and head pop:** allowed same cycle when full.
- **Simultaneous `valid_i` push and data pop:** allowed.
- **Pointers:** wrap modulo depth; occupancy counters are `$clog2(max_outstanding_p+1)` bits wide.

## Structure
- Package `axil_reg_bridge_pkg` holds:
  - resp constants: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11;
  - `bridge_tag_s` {we, derr};
  - the data-entry struct macro/params.
- Both queues are instances of one sub-module, `bsg_fifo_1r1w_small` (els_p=`max_outstanding_p`): the tag FIFO and the data FIFO.
- Arbiter and command register stay inline.

## Test plan
- **Single read:** AR 'h10, downstream returns 'hDEADBEEF with `gnt_i` same cycle → R 'hDEADBEEF, OKAY, at cycle 3, `addr_o`='h10, `be_o`='hF.
- **Partial write:** AW 'h20, W 'h11223344 strb 4'b0011 → `we_o`=1, `be_o`=4'b0011, `wdata_o` unchanged, B OKAY.
- **Out-of-window:** AR 'h0040_0000 with base 0, `reg_addr_width_p`=22 → `req_o` never asserts, R DECERR, rdata 0, at cycle 1.
- **Ordering:** reads A and C in window, write B out-of-window, issued back to back with a 5-cycle downstream latency → responses in order A(R), B(B, DECERR), C(R); B waits behind A.
- **Backpressure/full:** `max_outstanding_p`=2, `gnt_i` high, `valid_i` withheld → two accepts then all readies low. Then release `valid_i` with `rready`=0 → rvalid held stable until `rready`.
- **Contention and reset:** AW/W and AR held valid continuously → alternating W,R,W,R grants. Assert `reset_i` mid-burst → all outputs 0 in the same cycle (async), and the first accept after release is a write.
